seq_divider32: RTL and testbench
================================

// Module: seq_divider32
// PURPOSE
//  Multi-cycle restoring divider for the RV32M DIV/DIVU/REM/REMU ops; inverse arithmetic path to the adder datapath.
//  Sits beside the ALU in the execute stage; accepts one op at a time via valid/ready, returns a 32-bit result.
//  One quotient bit per cycle, computed with a dedicated 32-bit subtractor.
// PARAMETERS
//  WIDTH     32   operand/result width; only 32 supported (elaboration error otherwise)
//  (localparam CNT_W = $clog2(WIDTH) = 5, iteration counter width)
// PORTS
//  clk_i       in   1      clock, all state on rising edge
//  rst_ni      in   1      synchronous reset, active-low
//  valid_i     in   1      request valid
//  ready_o     out  1      divider can accept a request (high only in IDLE)
//  op_i        in   2      div_op_t: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//  dividend_i  in   WIDTH  rs1 operand
//  divisor_i   in   WIDTH  rs2 operand
//  valid_o     out  1      result valid (high only in DONE)
//  ready_i     in   1      consumer accepts result
//  result_o    out  WIDTH  quotient or remainder, per op
// BEHAVIOUR
//  Reset: state=IDLE, ready_o=1 after reset released, valid_o=0, result_o=0, internal regs=0.
//  Reset mid-operation aborts the op; no result is produced for it.
//  FSM: IDLE -> CALC -> SIGN -> DONE -> IDLE.
//   IDLE: on valid_i&&ready_o, capture op, |dividend|, |divisor| (magnitude only for signed ops),
//         result signs, zero-divisor flag; rem=0, cnt=0; go CALC.
//   CALC: each cycle shift {rem,quo} left 1; trial = rem' - divisor via subtractor32; if no borrow,
//         rem=trial and quo[0]=1, else keep rem and quo[0]=0; cnt++; after 32 iterations go SIGN.
//   SIGN: apply sign fix (quotient neg if sign(a)^sign(b), remainder takes sign(a)); apply special
//         cases; register result_o; go DONE.
//   DONE: valid_o=1, result_o stable; on ready_i go IDLE. No new request accepted in DONE.
//  Latency: valid_o rises 34 edges after the accepting edge (1 capture + 32 CALC + 1 SIGN).
//  Inputs are ignored outside the accepting cycle; operand changes during CALC have no effect.
//  Special cases (RISC-V defined, no traps):
//   divisor==0: DIV/DIVU -> 32'hFFFF_FFFF; REM/REMU -> dividend_i unchanged.
//   DIV overflow (0x8000_0000 / -1): quotient 0x8000_0000, remainder 0.
//  Magnitude of 0x8000_0000 is 0x8000_0000 interpreted unsigned; no overflow inside CALC.
// CONFIGURATION
//  SEQ_DIV_EARLY_OUT_EN defined: divisor==0 requests skip CALC/SIGN; the accepting edge loads the
//   special-case result and enters DONE, so valid_o rises 1 edge after acceptance. All other ops unchanged.
//  Not defined: every op, including divide-by-zero, takes the full 34-edge latency.
// STRUCTURE
//  Package seq_div_pkg: div_op_t enum (DIV, DIVU, REM, REMU), div_state_t enum (IDLE, CALC, SIGN, DONE),
//   XLEN=32, DIV_ITERS=32.
//  Sub-module subtractor32: a_i, b_i -> diff_o, borrow_o (combinational a-b); one instance in CALC path.
// TESTING
//  DIVU 100/7 -> result 14 at edge 34; REMU 100/7 -> 2; ready_o low from accept until return to IDLE.
//  DIV -7/2 -> 0xFFFF_FFFD (-3); REM -7/2 -> 0xFFFF_FFFF (-1); REM 7/-2 -> 1.
//  DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000; REM same operands -> 0.
//  DIVU 5/0 -> 0xFFFF_FFFF, REM -5/0 -> 0xFFFF_FFFB; latency 34 (macro off) / 1 (macro on).
//  Hold ready_i=0 for 10 cycles in DONE -> valid_o and result_o held; ready_i=1 -> IDLE next edge.
//  Assert rst_ni=0 at CALC iteration 15 -> next edge IDLE, valid_o=0, result_o=0; next op correct.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared types and constants for the RV32M sequential divider.
package seq_div_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN,
        DONE
    } div_state_t;

endpackage

// File: rtl/subtractor32.sv
// 32-bit combinational subtractor: diff = a - b, borrow when b > a.
module subtractor32
    import seq_div_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] diff_o,
    output logic            borrow_o
);

    assign {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};

endmodule

// File: rtl/seq_divider32.sv
// Restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// SEQ_DIV_EARLY_OUT_EN: divide-by-zero requests finish on the accepting edge.
module seq_divider32
    import seq_div_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  div_op_t          op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o
);

    localparam int CNT_W = $clog2(WIDTH);

    if (WIDTH != XLEN) begin : g_bad_width
        $error("seq_divider32 supports WIDTH=32 only");
    end

    div_state_t       state_q, state_d;
    div_op_t          op_q;
    logic [WIDTH-1:0] quo_q, rem_q, dvs_q, result_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_q_q, neg_r_q, zero_q;

    logic             accept, early;
    logic             is_signed, a_neg, b_neg, zero_in;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] rem_sh, quo_sh, diff;
    logic             borrow, take;
    logic [WIDTH-1:0] q_fix, r_fix, sign_res;

    assign ready_o  = (state_q == IDLE);
    assign valid_o  = (state_q == DONE);
    assign result_o = result_q;
    assign accept   = valid_i && ready_o;

    assign is_signed = ~op_i[0];
    assign a_neg     = is_signed & dividend_i[WIDTH-1];
    assign b_neg     = is_signed & divisor_i[WIDTH-1];
    assign a_mag     = a_neg ? -dividend_i : dividend_i;
    assign b_mag     = b_neg ? -divisor_i : divisor_i;
    assign zero_in   = (divisor_i == '0);

`ifdef SEQ_DIV_EARLY_OUT_EN
    assign early = zero_in;
`else
    assign early = 1'b0;
`endif

    // A set top bit before the shift means the trial always fits.
    assign rem_sh = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    assign quo_sh = {quo_q[WIDTH-2:0], 1'b0};
    assign take   = rem_q[WIDTH-1] | ~borrow;

    subtractor32 u_sub (
        .a_i      (rem_sh),
        .b_i      (dvs_q),
        .diff_o   (diff),
        .borrow_o (borrow)
    );

    // Zero divisor leaves rem=|a|, so the signed fix restores the dividend.
    assign q_fix    = neg_q_q ? -quo_q : quo_q;
    assign r_fix    = neg_r_q ? -rem_q : rem_q;
    assign sign_res = op_q[1] ? r_fix : (zero_q ? '1 : q_fix);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (valid_i) state_d = early ? DONE : CALC;
            CALC: if (cnt_q == CNT_W'(DIV_ITERS - 1)) state_d = SIGN;
            SIGN: state_d = DONE;
            DONE: if (ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            op_q     <= DIV;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            zero_q   <= 1'b0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (accept) begin
                    op_q    <= op_i;
                    quo_q   <= a_mag;
                    rem_q   <= '0;
                    dvs_q   <= b_mag;
                    cnt_q   <= '0;
                    neg_q_q <= (a_neg ^ b_neg) & ~zero_in;
                    neg_r_q <= a_neg;
                    zero_q  <= zero_in;
                    if (early) begin
                        result_q <= op_i[1] ? dividend_i : '1;
                    end
                end
                CALC: begin
                    rem_q <= take ? diff : rem_sh;
                    quo_q <= {quo_sh[WIDTH-1:1], take};
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                SIGN: result_q <= sign_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider32.sv
// Directed vector bench for seq_divider32: results, latency, hold and reset abort.
module tb_seq_divider32;
    import seq_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    div_op_t     op_i = DIV;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] result_o;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seq_divider32 dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .result_o   (result_o)
    );

    typedef struct {
        string       name;
        div_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] b);
`ifdef SEQ_DIV_EARLY_OUT_EN
        return (b == 32'd0) ? 1 : 34;
`else
        return 34;
`endif
    endfunction

    // Accept one op, scramble operands, wait for valid_o, then retire it.
    task automatic run_op(input vec_t v);
        int   lat;
        logic busy_bad;
        @(negedge clk);
        chk({v.name, "_ready_idle"}, 32'(ready_o), 32'd1);
        op_i = v.op;
        dividend_i = v.a;
        divisor_i = v.b;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        dividend_i = $urandom;
        divisor_i = $urandom;
        op_i = div_op_t'($urandom_range(0, 3));
        lat = 1;
        busy_bad = ready_o;
        while (!valid_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (ready_o) busy_bad = 1'b1;
        end
        chk({v.name, "_result"}, result_o, v.exp);
        chk({v.name, "_latency"}, 32'(lat), 32'(exp_lat(v.b)));
        chk({v.name, "_busy"}, 32'(busy_bad), 32'd0);
        @(negedge clk);
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
    endtask

    initial begin
        logic [31:0] held;
        logic        hold_bad;
        int          n;

        vecs[0]  = '{"divu_100_7",  DIVU, 32'd100,        32'd7,          32'd14};
        vecs[1]  = '{"remu_100_7",  REMU, 32'd100,        32'd7,          32'd2};
        vecs[2]  = '{"div_m7_2",    DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        vecs[3]  = '{"rem_m7_2",    REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        vecs[4]  = '{"rem_7_m2",    REM,  32'd7,          32'hFFFF_FFFE,  32'd1};
        vecs[5]  = '{"div_ovf",     DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[6]  = '{"rem_ovf",     REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[7]  = '{"divu_5_0",    DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[8]  = '{"rem_m5_0",    REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB};
        vecs[9]  = '{"div_m5_0",    DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF};
        vecs[10] = '{"remu_7_0",    REMU, 32'd7,          32'd0,          32'd7};
        vecs[11] = '{"divu_max_1",  DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
        vecs[12] = '{"div_m100_m7", DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14};
        vecs[13] = '{"remu_max_10", REMU, 32'hFFFF_FFFF,  32'd10,         32'd5};
        vecs[14] = '{"divu_big",    DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[15] = '{"remu_big",    REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_result", result_o, 32'd0);

        foreach (vecs[i]) run_op(vecs[i]);

        // Hold the result in DONE while the consumer stalls.
        @(negedge clk);
        op_i = DIVU;
        dividend_i = 32'd100;
        divisor_i = 32'd7;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        n = 1;
        while (!valid_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("hold_first", result_o, 32'd14);
        held = result_o;
        hold_bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (!valid_o || result_o !== held || ready_o) hold_bad = 1'b1;
        end
        chk("hold_stable", 32'(hold_bad), 32'd0);
        @(negedge clk);
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        chk("hold_release_ready", 32'(ready_o), 32'd1);
        chk("hold_release_valid", 32'(valid_o), 32'd0);

        // Abort in the middle of CALC.
        @(negedge clk);
        op_i = DIV;
        dividend_i = 32'hFFFF_FFF9;
        divisor_i = 32'd2;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_valid", 32'(valid_o), 32'd0);
        chk("abort_result", result_o, 32'd0);
        chk("abort_ready", 32'(ready_o), 32'd1);
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort_no_result", 32'(valid_o), 32'd0);
        end
        run_op(vecs[2]);
        run_op(vecs[13]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
